// File: rtl/btb_pkg.sv
// Shared BTB geometry, sequencer states and entry-formatting helpers.
// The predict stage uses the same helpers, so index and word layout stay in one place.
package btb_pkg;

  localparam int BTB_IDX_W   = 11;
  localparam int BTB_TAG_W   = 2;
  localparam int BTB_VAL_W   = 13;
  localparam int BTB_ENTRIES = 2048;
  localparam int BTB_WORD_W  = 1 + BTB_TAG_W + BTB_VAL_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } btb_state_e;

  function automatic logic [BTB_IDX_W-1:0] btb_index(input logic [31:0] pc);
    return pc[12:2];
  endfunction

  // Word layout: {valid, tag = pc[14:13], target = nextpc[14:2]}
  function automatic logic [BTB_WORD_W-1:0] btb_word(input logic [31:0] pc,
                                                     input logic [31:0] nextpc);
    return {1'b1, pc[14:13], nextpc[14:2]};
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small update FIFO holding {index, word} pairs.
// The newest entry's word can be overwritten in place, which lets repeated writes coalesce.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = BTB_IDX_W,
  parameter int WORD_W = BTB_WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              overwrite,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic [WORD_W-1:0] push_word,
  output logic [IDX_W-1:0]  head_idx,
  output logic [WORD_W-1:0] head_word,
  output logic [IDX_W-1:0]  tail_idx,
  output logic              full,
  output logic              empty,
  output logic              one
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [IDX_W-1:0]  idx_mem  [DEPTH];
  logic [WORD_W-1:0] word_mem [DEPTH];
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  tail_ptr;

  // Extra pointer bit separates full from empty; DEPTH must be a power of two.
  assign count     = wr_ptr - rd_ptr;
  assign tail_ptr  = wr_ptr[PTR_W-1:0] - PTR_ONE[PTR_W-1:0];
  assign full      = (count == {1'b1, {PTR_W{1'b0}}});
  assign empty     = (count == '0);
  assign one       = (count == PTR_ONE);
  assign head_idx  = idx_mem[rd_ptr[PTR_W-1:0]];
  assign head_word = word_mem[rd_ptr[PTR_W-1:0]];
  assign tail_idx  = idx_mem[tail_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!clear) begin
      if (push) begin
        idx_mem[wr_ptr[PTR_W-1:0]]  <= push_idx;
        word_mem[wr_ptr[PTR_W-1:0]] <= push_word;
      end else if (overwrite) begin
        word_mem[tail_ptr] <= push_word;
      end
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: clears every entry after reset/flush, then arbitrates,
// buffers and coalesces D/E mispredict updates onto the single write port.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int IDX_W      = BTB_IDX_W,
  parameter int TAG_W      = BTB_TAG_W,
  parameter int VAL_W      = BTB_VAL_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   fail_predictD,
  input  logic [31:0]            pcD,
  input  logic [31:0]            nextpcD,
  input  logic                   fail_predictE,
  input  logic [31:0]            pcE,
  input  logic [31:0]            nextpcE,
  input  logic                   flush_req,
  input  logic                   port_busy,
  output logic [IDX_W-1:0]       w_addr,
  output logic [TAG_W+VAL_W:0]   w_data,
  output logic                   wen,
  output logic                   init_busy,
  output logic [7:0]             drop_cnt
);

  localparam int WORD_W = 1 + TAG_W + VAL_W;
  localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

  btb_state_e        state, state_d;
  logic [IDX_W:0]    cnt, cnt_d;
  logic              wen_d;
  logic [IDX_W-1:0]  w_addr_d;
  logic [WORD_W-1:0] w_data_d;

  logic              cand_vld;
  logic [IDX_W-1:0]  cand_idx;
  logic [WORD_W-1:0] cand_word;
  logic              deq, enq, coalesce, drop;
  logic [IDX_W-1:0]  head_idx, tail_idx;
  logic [WORD_W-1:0] head_word;
  logic              fifo_full, fifo_empty, fifo_one;

  // E is older than D, so an E mispredict squashes D as wrong-path work.
  assign cand_vld  = fail_predictE | fail_predictD;
  assign cand_idx  = fail_predictE ? btb_index(pcE) : btb_index(pcD);
  assign cand_word = fail_predictE ? btb_word(pcE, nextpcE) : btb_word(pcD, nextpcD);

  // FIFO handshake: push/overwrite land on the clock edge; pop takes the head
  // on the same edge it is registered to the write port. Flush overrides both.
  assign deq      = (state == RUN) && !fifo_empty && !port_busy && !flush_req;
  assign coalesce = (state == RUN) && !flush_req && cand_vld && !fifo_empty &&
                    (cand_idx == tail_idx) && !(deq && fifo_one);
  assign enq      = (state == RUN) && !flush_req && cand_vld && !coalesce &&
                    (!fifo_full || deq);
  assign drop     = cand_vld && !coalesce && !enq;

  btb_upd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .IDX_W  (IDX_W),
    .WORD_W (WORD_W)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (flush_req),
    .push      (enq),
    .pop       (deq),
    .overwrite (coalesce),
    .push_idx  (cand_idx),
    .push_word (cand_word),
    .head_idx  (head_idx),
    .head_word (head_word),
    .tail_idx  (tail_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .one       (fifo_one)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    wen_d    = 1'b0;
    w_addr_d = w_addr;
    w_data_d = w_data;
    if (flush_req) begin
      state_d = INIT;
      cnt_d   = '0;
    end else begin
      case (state)
        INIT: begin
          // cnt's top bit marks that the last entry has been issued.
          if (cnt[IDX_W]) begin
            state_d = RUN;
          end else if (!port_busy) begin
            wen_d    = 1'b1;
            w_addr_d = cnt[IDX_W-1:0];
            w_data_d = '0;
            cnt_d    = cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (deq) begin
            wen_d    = 1'b1;
            w_addr_d = head_idx;
            w_data_d = head_word;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= INIT;
      cnt       <= '0;
      wen       <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      init_busy <= 1'b1;
      drop_cnt  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      wen       <= wen_d;
      w_addr    <= w_addr_d;
      w_data    <= w_data_d;
      init_busy <= (state_d == INIT);
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: expected BTB writes are queued by the
// stimulus and matched in order by a negedge monitor.
module tb_btb_update_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fail_predictD = 1'b0;
  logic        fail_predictE = 1'b0;
  logic        flush_req = 1'b0;
  logic        port_busy = 1'b0;
  logic [31:0] pcD = '0, nextpcD = '0, pcE = '0, nextpcE = '0;
  logic [10:0] w_addr;
  logic [15:0] w_data;
  logic        wen;
  logic        init_busy;
  logic [7:0]  drop_cnt;

  logic [26:0] exp_q[$];
  logic [26:0] mon_exp;
  int          checks = 0;
  int          passes = 0;

  // Six distinct-index updates; the last two overflow the 4-entry buffer.
  logic [31:0] v_pc[6]   = '{32'h0000_0100, 32'h0000_2104, 32'h0000_4108,
                             32'hFFFF_E10F, 32'h0000_0114, 32'h0000_0118};
  logic [31:0] v_np[6]   = '{32'h0000_0200, 32'h0000_4008, 32'h0000_7FFC,
                             32'h0000_0003, 32'h0000_0400, 32'h0000_0500};
  logic [26:0] v_exp[4]  = '{{11'h040, 16'h8080}, {11'h041, 16'hB002},
                             {11'h042, 16'hDFFF}, {11'h043, 16'hE000}};

  always #5 CLK = ~CLK;

  btb_update_ctrl dut (
    .CLK           (CLK),
    .RST           (RST),
    .fail_predictD (fail_predictD),
    .pcD           (pcD),
    .nextpcD       (nextpcD),
    .fail_predictE (fail_predictE),
    .pcE           (pcE),
    .nextpcE       (nextpcE),
    .flush_req     (flush_req),
    .port_busy     (port_busy),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .wen           (wen),
    .init_busy     (init_busy),
    .drop_cnt      (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_sweep;
    for (int i = 0; i < 2048; i++) exp_q.push_back({11'(i), 16'h0000});
  endtask

  task automatic wait_sweep(input int exp_n, input string name);
    int n = 0;
    while (init_busy && n < 2300) begin
      step;
      n++;
    end
    chk({name, "_cycles"}, 32'(n), 32'(exp_n));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step;
      n++;
    end
    repeat (5) step;
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every write the DUT presents must be the next queued expectation.
  always @(negedge CLK) begin
    if (wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", w_addr, w_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("write", 32'({w_addr, w_data}), 32'(mon_exp));
      end
    end
  end

  initial begin
    // Reset values
    step;
    step;
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_addr", 32'(w_addr), 32'd0);
    chk("rst_data", 32'(w_data), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Initial sweep, unblocked
    push_sweep;
    RST = 1'b0;
    wait_sweep(2049, "sweep0");
    chk("sweep0_drop", 32'(drop_cnt), 32'd0);

    // Simultaneous D and E: E wins, D discarded uncounted; check latency
    fail_predictD = 1'b1; pcD = 32'h0000_8010; nextpcD = 32'h0000_1234;
    fail_predictE = 1'b1; pcE = 32'h0000_9004; nextpcE = 32'h0000_8100;
    exp_q.push_back({11'h401, 16'h8040});
    step;
    fail_predictD = 1'b0;
    fail_predictE = 1'b0;
    chk("lat_wen_k", 32'(wen), 32'd0);
    step;
    chk("lat_wen_k1", 32'(wen), 32'd1);
    chk("lat_addr", 32'(w_addr), 32'h401);
    wait_drain("de_arb");
    chk("de_arb_drop", 32'(drop_cnt), 32'd0);

    // Coalescing two writes to the same index while blocked
    port_busy = 1'b1;
    fail_predictD = 1'b1; pcD = 32'h0000_8020; nextpcD = 32'h0000_8200;
    step;
    nextpcD = 32'h0000_8300;
    step;
    fail_predictD = 1'b0;
    step;
    step;
    chk("busy_no_wen", 32'(wen), 32'd0);
    exp_q.push_back({11'h008, 16'h80C0});
    port_busy = 1'b0;
    wait_drain("coalesce");
    chk("coalesce_drop", 32'(drop_cnt), 32'd0);

    // Overflow: six distinct updates, four kept in order, two dropped
    port_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 1) begin
        fail_predictE = 1'b1; pcE = v_pc[i]; nextpcE = v_np[i];
      end else begin
        fail_predictD = 1'b1; pcD = v_pc[i]; nextpcD = v_np[i];
      end
      step;
      fail_predictD = 1'b0;
      fail_predictE = 1'b0;
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(v_exp[i]);
    port_busy = 1'b0;
    wait_drain("overflow");
    chk("overflow_drop", 32'(drop_cnt), 32'd2);

    // Flush with three buffered entries plus a same-cycle candidate
    port_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fail_predictD = 1'b1; pcD = 32'h0000_0140 + 32'(4 * i); nextpcD = 32'h0000_0600;
      step;
    end
    pcD = 32'h0000_014C;
    flush_req = 1'b1;
    port_busy = 1'b0;
    step;
    flush_req = 1'b0;
    fail_predictD = 1'b0;
    chk("flush_init_busy", 32'(init_busy), 32'd1);
    chk("flush_wen", 32'(wen), 32'd0);
    chk("flush_drop", 32'(drop_cnt), 32'd3);
    push_sweep;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        fail_predictE = 1'b1; pcE = 32'h0000_0200; nextpcE = 32'h0000_0300;
      end
      step;
      fail_predictE = 1'b0;
    end
    chk("sweep_update_drop", 32'(drop_cnt), 32'd4);
    wait_sweep(2039, "sweep1");
    chk("sweep1_drop", 32'(drop_cnt), 32'd4);

    // RST mid-sweep at address 1000
    push_sweep;
    flush_req = 1'b1;
    step;
    flush_req = 1'b0;
    begin
      int n = 0;
      while (!(wen && w_addr == 11'd1000) && n < 1100) begin
        step;
        n++;
      end
      chk("reach_addr_1000", 32'(wen && w_addr == 11'd1000), 32'd1);
    end
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_wen", 32'(wen), 32'd0);
    chk("rst_mid_addr", 32'(w_addr), 32'd0);
    chk("rst_mid_data", 32'(w_data), 32'd0);
    chk("rst_mid_init_busy", 32'(init_busy), 32'd1);
    chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    push_sweep;
    step;
    RST = 1'b0;
    // Hold a D update through the whole sweep to drive drop_cnt into saturation
    fail_predictD = 1'b1; pcD = 32'h0000_0500; nextpcD = 32'h0000_0700;
    wait_sweep(2049, "sweep2");
    fail_predictD = 1'b0;
    chk("drop_saturated", 32'(drop_cnt), 32'd255);
    repeat (5) step;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_no_wen", 32'(wen), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
